// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layer controller: state encoding,
// decoded-output bundle and derived-constant helpers.
package conv_pkg;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StUpd  = 3'd2;
    localparam logic [2:0] StRun  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    typedef struct packed {
        logic en_array;
        logic en_cnt;
        logic en_dff_pixel;
        logic en_dff_weight;
        logic ud_pixel;
        logic ud_weight;
        logic flush;
        logic valid;
    } dec_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned p_of(input int unsigned taps, input int unsigned win_per_k);
        return taps * win_per_k;
    endfunction

    function automatic int unsigned t_of(input int unsigned taps, input int unsigned win_per_k,
                                         input int unsigned num_k);
        return taps * win_per_k * num_k;
    endfunction

endpackage

// File: rtl/conv_layer_ctrl_if.sv
// Control/status bundle of the convolution layer controller.
interface conv_layer_ctrl_if
    import conv_pkg::*;
#(
    parameter int unsigned TAPS      = 9,
    parameter int unsigned WIN_PER_K = 2,
    parameter int unsigned NUM_K     = 32,
    parameter int unsigned PIX_LD    = 300
);
    localparam int unsigned IW = cnt_w(PIX_LD + 2);
    localparam int unsigned DW = cnt_w(t_of(TAPS, WIN_PER_K, NUM_K));
    localparam int unsigned KW = cnt_w(NUM_K);

    logic          sta;
    logic          cont;
    logic          stall;
    logic          abort;
    logic          busy;
    logic          done;
    logic [2:0]    state;
    logic [IW-1:0] init_cnt;
    logic [DW-1:0] data_cnt;
    logic          en_array;
    logic          en_cnt;
    logic          en_DFF_pixel;
    logic          en_DFF_weight;
    logic          ud_pixel;
    logic          ud_weight;
    logic          flush;
    logic          valid_o;
    logic [KW-1:0] weight_num;

    modport master (
        output sta, cont, stall, abort,
        input  busy, done, state, init_cnt, data_cnt, en_array, en_cnt, en_DFF_pixel,
               en_DFF_weight, ud_pixel, ud_weight, flush, valid_o, weight_num
    );

    modport slave (
        input  sta, cont, stall, abort,
        output busy, done, state, init_cnt, data_cnt, en_array, en_cnt, en_DFF_pixel,
               en_DFF_weight, ud_pixel, ud_weight, flush, valid_o, weight_num
    );

endinterface

// File: rtl/conv_phase_dec.sv
// Tracks data_cnt mod TAPS and data_cnt mod P incrementally; relies on the run
// counter only ever holding, stepping by one, or returning to zero.
module conv_phase_dec
    import conv_pkg::*;
#(
    parameter int unsigned TAPS = 9,
    parameter int unsigned P    = 18,
    parameter int unsigned CntW = 10,
    localparam int unsigned PhW = cnt_w(TAPS),
    localparam int unsigned PkW = cnt_w(P)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CntW-1:0] cnt_d_i,
    input  logic [CntW-1:0] cnt_q_i,
    output logic [PhW-1:0]  ph_o,
    output logic [PkW-1:0]  pk_o
);
    localparam logic [PhW-1:0] PhLast = PhW'(TAPS - 1);
    localparam logic [PkW-1:0] PkLast = PkW'(P - 1);

    logic [PhW-1:0] ph_q, ph_d;
    logic [PkW-1:0] pk_q, pk_d;

    always_comb begin
        ph_d = ph_q;
        pk_d = pk_q;
        if (cnt_d_i == '0) begin
            ph_d = '0;
            pk_d = '0;
        end else if (cnt_d_i != cnt_q_i) begin
            ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
            pk_d = (pk_q == PkLast) ? '0 : pk_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q <= '0;
            pk_q <= '0;
        end else begin
            ph_q <= ph_d;
            pk_q <= pk_d;
        end
    end

    assign ph_o = ph_q;
    assign pk_o = pk_q;

endmodule

// File: rtl/conv_layer_ctrl.sv
// Convolution layer sequencer: loads pixels, then streams windows through the
// array with registered enable/update decodes, single-shot or continuous.
module conv_layer_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned TAPS      = 9,
    parameter int unsigned WIN_PER_K = 2,
    parameter int unsigned NUM_K     = 32,
    parameter int unsigned PIX_LD    = 300,
    parameter int unsigned DRAIN     = 2
) (
    input logic              clk,
    input logic              rst_n,
    conv_layer_ctrl_if.slave bus
);
    localparam int unsigned P   = p_of(TAPS, WIN_PER_K);
    localparam int unsigned T   = t_of(TAPS, WIN_PER_K, NUM_K);
    localparam int unsigned IW  = cnt_w(PIX_LD + 2);
    localparam int unsigned DW  = cnt_w(T);
    localparam int unsigned KW  = cnt_w(NUM_K);
    localparam int unsigned PhW = cnt_w(TAPS);
    localparam int unsigned PkW = cnt_w(P);
    localparam int          ArrLim = int'(TAPS) - 1 - int'(DRAIN);

    localparam logic [IW-1:0] InitLast = IW'(PIX_LD - 1);
    localparam logic [DW-1:0] DataLast = DW'(T - 1);
    localparam logic [KW-1:0] KLast    = KW'(NUM_K - 1);

    if (PIX_LD >= T || TAPS < 4) begin : g_cfg_err
        $error("conv_layer_ctrl: need TAPS >= 4 and PIX_LD < TAPS*WIN_PER_K*NUM_K");
    end

    logic [2:0]     state_q, state_d;
    logic [IW-1:0]  init_cnt_q, init_cnt_d;
    logic [DW-1:0]  data_cnt_q, data_cnt_d;
    logic [KW-1:0]  wnum_q, wnum_d;
    logic           cont_q, cont_d;
    dec_t           dec_q, dec_d;
    logic [PhW-1:0] ph;
    logic [PkW-1:0] pk;

    conv_phase_dec #(
        .TAPS (TAPS),
        .P    (P),
        .CntW (DW)
    ) u_phase_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_d_i (data_cnt_d),
        .cnt_q_i (data_cnt_q),
        .ph_o    (ph),
        .pk_o    (pk)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        data_cnt_d = data_cnt_q;
        wnum_d     = wnum_q;
        cont_d     = cont_q;
        dec_d      = '0;
        if (bus.abort) begin
            state_d    = StIdle;
            init_cnt_d = '0;
            data_cnt_d = '0;
            wnum_d     = '0;
            cont_d     = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.sta) begin
                        state_d    = StLoad;
                        cont_d     = bus.cont;
                        init_cnt_d = '0;
                    end
                end
                StLoad: begin
                    dec_d.en_dff_pixel  = 1'b1;
                    dec_d.en_dff_weight = (32'(init_cnt_q) < TAPS);
                    wnum_d              = '1;
                    if (init_cnt_q == InitLast) begin
                        state_d    = StUpd;
                        init_cnt_d = '0;
                    end else begin
                        init_cnt_d = init_cnt_q + 1'b1;
                    end
                end
                StUpd: begin
                    dec_d.ud_pixel  = 1'b1;
                    dec_d.ud_weight = 1'b1;
                    dec_d.en_array  = 1'b1;
                    dec_d.en_cnt    = 1'b1;
                    state_d         = StRun;
                    data_cnt_d      = '0;
                end
                StRun: begin
                    // A stalled cycle holds everything and decodes to all-zero.
                    if (!bus.stall) begin
                        dec_d.en_array      = (int'(ph) < ArrLim) || (32'(ph) == TAPS - 1);
                        dec_d.en_cnt        = dec_d.en_array;
                        dec_d.flush         = (32'(ph) == TAPS - 1);
                        dec_d.valid         = dec_d.flush;
                        dec_d.en_dff_weight = (32'(pk) < TAPS);
                        dec_d.ud_weight     = (32'(pk) == P - 2);
                        dec_d.en_dff_pixel  = cont_q && (32'(data_cnt_q) < PIX_LD);
                        dec_d.ud_pixel      = cont_q && (32'(data_cnt_q) == T - 2);
                        if (pk == '0) begin
                            wnum_d = ((wnum_q == KLast) || (&wnum_q)) ? '0 : wnum_q + 1'b1;
                        end
                        if (data_cnt_q == DataLast) begin
                            data_cnt_d = '0;
                            if (!cont_q) state_d = StDone;
                        end else begin
                            data_cnt_d = data_cnt_q + 1'b1;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            init_cnt_q <= '0;
            data_cnt_q <= '0;
            wnum_q     <= '0;
            cont_q     <= 1'b0;
            dec_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            data_cnt_q <= data_cnt_d;
            wnum_q     <= wnum_d;
            cont_q     <= cont_d;
            dec_q      <= dec_d;
        end
    end

    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = (state_q == StDone);
    assign bus.state         = state_q;
    assign bus.init_cnt      = init_cnt_q;
    assign bus.data_cnt      = data_cnt_q;
    assign bus.weight_num    = wnum_q;
    assign bus.en_array      = dec_q.en_array;
    assign bus.en_cnt        = dec_q.en_cnt;
    assign bus.en_DFF_pixel  = dec_q.en_dff_pixel;
    assign bus.en_DFF_weight = dec_q.en_dff_weight;
    assign bus.ud_pixel      = dec_q.ud_pixel;
    assign bus.ud_weight     = dec_q.ud_weight;
    assign bus.flush         = dec_q.flush;
    assign bus.valid_o       = dec_q.valid;

endmodule
